// File: rtl/ghpi_bus_arbiter_pkg.sv
// Shared state encodings and master IDs for the GHPI two-master bus arbiter.
package ghpi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE   = 2'd0,
    ARB_ST_LOCK_I = 2'd1,
    ARB_ST_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic ARB_M_I = 1'b0;
  localparam logic ARB_M_D = 1'b1;

endpackage

// File: rtl/ghpi_bus_arbiter_winner_sel.sv
// Combinational IDLE-state winner pick. ARB_ROUND_ROBIN_EN alternates on contention;
// otherwise dmem has fixed priority.
module ghpi_bus_arbiter_winner_sel
  import ghpi_bus_arbiter_pkg::*;
(
  input  logic imem_valid_i,
  input  logic dmem_valid_i,
  input  logic last_grant_i,
  output logic winner_o,
  output logic any_req_o
);

  assign any_req_o = imem_valid_i | dmem_valid_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner_o = dmem_valid_i ? ARB_M_D : ARB_M_I;
    if (imem_valid_i && dmem_valid_i) winner_o = ~last_grant_i;
  end
`else
  // dmem first: stage2 stalls stage1, so serving imem first could deadlock the core.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign winner_o = dmem_valid_i ? ARB_M_D : ARB_M_I;
`endif

endmodule

// File: rtl/ghpi_bus_arbiter.sv
// Two-master (imem/dmem) to one-slave GHPI arbiter; grant locks until slave ack or abort.
// Optional ARB_ROUND_ROBIN_EN switches contention policy from dmem-priority to alternating.
module ghpi_bus_arbiter
  import ghpi_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_data_o,
  input  logic                  imem_valid_i,
  output logic                  imem_ack_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_data_i,
  output logic [DATA_WIDTH-1:0] dmem_data_o,
  input  logic [SW-1:0]         dmem_sel_i,
  input  logic                  dmem_we_i,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ack_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic [SW-1:0]         bus_sel_o,
  output logic                  bus_we_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ack_i
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       winner, any_req;
  logic       sel_d, sel_valid, hs;

  ghpi_bus_arbiter_winner_sel u_winner_sel (
    .imem_valid_i (imem_valid_i),
    .dmem_valid_i (dmem_valid_i),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_ST_IDLE;
      last_grant_q <= ARB_M_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Owner of the bus this cycle: the locked master, or the fresh winner in IDLE.
  always_comb begin
    sel_d = 1'b0;
    case (state_q)
      ARB_ST_LOCK_D: sel_d = 1'b1;
      ARB_ST_LOCK_I: sel_d = 1'b0;
      default:       sel_d = (winner == ARB_M_D);
    endcase
  end

  assign sel_valid = sel_d ? dmem_valid_i : imem_valid_i;
  assign hs        = sel_valid & bus_ack_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (hs) last_grant_d = sel_d;
    case (state_q)
      ARB_ST_IDLE: begin
        if (any_req && !bus_ack_i)
          state_d = (winner == ARB_M_D) ? ARB_ST_LOCK_D : ARB_ST_LOCK_I;
      end
      ARB_ST_LOCK_I, ARB_ST_LOCK_D: begin
        // Ack completes; a dropped owner valid aborts without ack.
        if (bus_ack_i || !sel_valid) state_d = ARB_ST_IDLE;
      end
      default: state_d = ARB_ST_IDLE;
    endcase
  end

  assign bus_valid_o = ~rst_i & sel_valid;
  assign bus_we_o    = ~rst_i & sel_d & dmem_we_i;
  assign bus_addr_o  = sel_d ? dmem_addr_i : imem_addr_i;
  assign bus_data_o  = sel_d ? dmem_data_i : '0;
  assign bus_sel_o   = sel_d ? dmem_sel_i  : '1;

  assign imem_ack_o  = ~rst_i & bus_ack_i & ~sel_d & imem_valid_i;
  assign dmem_ack_o  = ~rst_i & bus_ack_i &  sel_d & dmem_valid_i;
  assign imem_data_o = bus_data_i;
  assign dmem_data_o = bus_data_i;

endmodule

// File: tb/tb_ghpi_bus_arbiter.sv
// Directed-vector bench for ghpi_bus_arbiter; expectations hand-derived from the arbiter behaviour.
module tb_ghpi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  dmem_sel, bus_sel;
  logic        imem_valid, imem_ack, dmem_we, dmem_valid, dmem_ack;
  logic        bus_we, bus_valid, bus_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ghpi_bus_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_i  (imem_addr),
    .imem_data_o  (imem_rdata),
    .imem_valid_i (imem_valid),
    .imem_ack_o   (imem_ack),
    .dmem_addr_i  (dmem_addr),
    .dmem_data_i  (dmem_wdata),
    .dmem_data_o  (dmem_rdata),
    .dmem_sel_i   (dmem_sel),
    .dmem_we_i    (dmem_we),
    .dmem_valid_i (dmem_valid),
    .dmem_ack_o   (dmem_ack),
    .bus_addr_o   (bus_addr),
    .bus_data_o   (bus_wdata),
    .bus_data_i   (bus_rdata),
    .bus_sel_o    (bus_sel),
    .bus_we_o     (bus_we),
    .bus_valid_o  (bus_valid),
    .bus_ack_i    (bus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen mid-cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic chk_acks(input string tag, input logic ei, input logic ed);
    chk({tag, ".iack"}, {31'd0, imem_ack}, {31'd0, ei});
    chk({tag, ".dack"}, {31'd0, dmem_ack}, {31'd0, ed});
  endtask

  initial begin
    rst = 1'b1; imem_addr = '0; imem_valid = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_sel = '0; dmem_we = 1'b0; dmem_valid = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;
    tick; tick;
    // Reset gating: requests and ack during reset must not reach the bus or masters.
    imem_valid = 1'b1; dmem_valid = 1'b1; dmem_we = 1'b1; bus_ack = 1'b1;
    settle;
    chk("rst.bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst.bus_we", {31'd0, bus_we}, 32'd0);
    chk_acks("rst", 1'b0, 1'b0);
    tick;
    rst = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0; dmem_we = 1'b0; bus_ack = 1'b0;
    tick;

    // T1: imem read, zero-wait slave.
    imem_valid = 1'b1; imem_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    settle;
    chk("t1.addr", bus_addr, 32'h100);
    chk("t1.valid", {31'd0, bus_valid}, 32'd1);
    chk("t1.we", {31'd0, bus_we}, 32'd0);
    chk("t1.sel", {28'd0, bus_sel}, 32'hF);
    chk("t1.wdata", bus_wdata, 32'd0);
    chk("t1.rdata", imem_rdata, 32'hDEADBEEF);
    chk_acks("t1", 1'b1, 1'b0);
    tick;
    imem_valid = 1'b0; bus_ack = 1'b0;
    tick;

    // T2: contention, dmem write wins; imem served next cycle.
    imem_valid = 1'b1; imem_addr = 32'h100;
    dmem_valid = 1'b1; dmem_addr = 32'h2004; dmem_wdata = 32'h55; dmem_sel = 4'b0010; dmem_we = 1'b1;
    bus_ack = 1'b1;
    settle;
    chk("t2.addr", bus_addr, 32'h2004);
    chk("t2.wdata", bus_wdata, 32'h55);
    chk("t2.sel", {28'd0, bus_sel}, 32'h2);
    chk("t2.we", {31'd0, bus_we}, 32'd1);
    chk_acks("t2", 1'b0, 1'b1);
    tick;
    dmem_valid = 1'b0; dmem_we = 1'b0;
    settle;
    chk("t2b.addr", bus_addr, 32'h100);
    chk_acks("t2b", 1'b1, 1'b0);
    tick;
    imem_valid = 1'b0; bus_ack = 1'b0;
    tick;

    // T3: imem locked for a 3-cycle wait; dmem arriving mid-lock must wait.
    imem_valid = 1'b1; imem_addr = 32'h300;
    settle;
    chk("t3.c0.addr", bus_addr, 32'h300);
    chk_acks("t3.c0", 1'b0, 1'b0);
    tick;
    dmem_valid = 1'b1; dmem_addr = 32'h400; dmem_we = 1'b1; dmem_sel = 4'hC;
    for (int c = 1; c < 3; c++) begin
      settle;
      chk($sformatf("t3.c%0d.addr", c), bus_addr, 32'h300);
      chk($sformatf("t3.c%0d.we", c), {31'd0, bus_we}, 32'd0);
      chk_acks($sformatf("t3.c%0d", c), 1'b0, 1'b0);
      tick;
    end
    bus_ack = 1'b1;
    settle;
    chk("t3.c3.addr", bus_addr, 32'h300);
    chk_acks("t3.c3", 1'b1, 1'b0);
    tick;
    imem_valid = 1'b0;
    settle;
    chk("t3.d.addr", bus_addr, 32'h400);
    chk("t3.d.we", {31'd0, bus_we}, 32'd1);
    chk_acks("t3.d", 1'b0, 1'b1);
    tick;
    dmem_valid = 1'b0; dmem_we = 1'b0; bus_ack = 1'b0;
    tick;

    // T4: reset during a LOCK_D drops the transaction.
    dmem_valid = 1'b1; dmem_addr = 32'h500; dmem_we = 1'b1;
    settle;
    chk("t4.c0.addr", bus_addr, 32'h500);
    tick;
    tick;
    rst = 1'b1; bus_ack = 1'b1;
    settle;
    chk("t4.rst.valid", {31'd0, bus_valid}, 32'd0);
    chk_acks("t4.rst", 1'b0, 1'b0);
    tick;
    rst = 1'b0; dmem_valid = 1'b0; dmem_we = 1'b0;
    imem_valid = 1'b1; imem_addr = 32'h600;
    settle;
    chk("t4.post.addr", bus_addr, 32'h600);
    chk("t4.post.valid", {31'd0, bus_valid}, 32'd1);
    chk_acks("t4.post", 1'b1, 1'b0);
    tick;
    imem_valid = 1'b0; bus_ack = 1'b0;
    tick;

    // T5: dmem aborts inside LOCK_D; imem granted afterwards.
    dmem_valid = 1'b1; dmem_addr = 32'h700;
    tick;
    dmem_valid = 1'b0; imem_valid = 1'b1; imem_addr = 32'h800;
    settle;
    chk("t5.abort.valid", {31'd0, bus_valid}, 32'd0);
    chk("t5.abort.addr", bus_addr, 32'h700);
    chk_acks("t5.abort", 1'b0, 1'b0);
    tick;
    bus_ack = 1'b1;
    settle;
    chk("t5.next.addr", bus_addr, 32'h800);
    chk_acks("t5.next", 1'b1, 1'b0);
    tick;
    imem_valid = 1'b0;

    // Stray ack with no request is ignored.
    settle;
    chk("stray.valid", {31'd0, bus_valid}, 32'd0);
    chk_acks("stray", 1'b0, 1'b0);
    tick;

    // T6: sustained contention with zero-wait slave. Last handshake was imem.
    imem_valid = 1'b1; imem_addr = 32'h900;
    dmem_valid = 1'b1; dmem_addr = 32'hA00;
    for (int c = 0; c < 4; c++) begin
      settle;
`ifdef ARB_ROUND_ROBIN_EN
      chk_acks($sformatf("t6.c%0d", c), c[0], ~c[0]);
`else
      chk_acks($sformatf("t6.c%0d", c), 1'b0, 1'b1);
`endif
      tick;
    end
    imem_valid = 1'b0; dmem_valid = 1'b0; bus_ack = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
